// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine transaction controller.
//   state_t        : controller states
//   VAL_N/D/Q      : coin values in cents
//   DEF_PRICE      : default product price in cents
//   DEF_MAX_CREDIT : default credit ceiling in cents
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam int VAL_N = 5;
    localparam int VAL_D = 10;
    localparam int VAL_Q = 25;

    localparam int DEF_PRICE      = 75;
    localparam int DEF_MAX_CREDIT = 200;

endpackage

// File: rtl/vend_controller_change_dispenser.sv
// Greedy change-return step. This block is combinational; the caller registers
// its outputs. Each step it picks the largest coin that still fits in the credit.
//   start       : step enable (controller is in CHANGE)
//   credit      : credit still to be returned
//   eject_q/d/n : coin to return on this step (at most one is high)
//   credit_next : credit left after this step
//   done        : this step brings the credit to zero
module change_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    output logic                eject_q,
    output logic                eject_d,
    output logic                eject_n,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] C_Q = CREDIT_W'(VAL_Q);
    localparam logic [CREDIT_W-1:0] C_D = CREDIT_W'(VAL_D);
    localparam logic [CREDIT_W-1:0] C_N = CREDIT_W'(VAL_N);

    always_comb begin
        eject_q     = 1'b0;
        eject_d     = 1'b0;
        eject_n     = 1'b0;
        credit_next = credit;
        if (start) begin
            if (credit >= C_Q) begin
                eject_q     = 1'b1;
                credit_next = credit - C_Q;
            end else if (credit >= C_D) begin
                eject_d     = 1'b1;
                credit_next = credit - C_D;
            end else if (credit >= C_N) begin
                eject_n     = 1'b1;
                credit_next = credit - C_N;
            end else begin
                // Credit is always a multiple of 5; this arm only drains a stray
                // sub-nickel remainder without underflowing.
                credit_next = '0;
            end
        end
    end

    assign done = start && (credit_next == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending-machine transaction controller. Tracks credit from coin pulses,
// dispenses on select when credit covers PRICE, and returns change or refunds
// one coin per cycle. All outputs are registered.
//   clk, reset              : clock, asynchronous active-low reset
//   coin_n/coin_d/coin_q    : coin-insert pulses (5c/10c/25c)
//   select, cancel          : purchase / refund request pulses
//   credit                  : current credit in cents
//   dispense                : product actuator, high DISPENSE_CYCLES cycles
//   eject_q/eject_d/eject_n : change-return pulses
//   coin_reject             : coin refused
//   deny                    : select with insufficient credit
//   busy                    : in DISPENSE or CHANGE
//
// state    | meaning
// IDLE     | no credit, waiting for a coin
// COLLECT  | credit accumulating, waiting for select/cancel
// DISPENSE | product actuator driven, counter running
// CHANGE   | returning remaining credit one coin per cycle
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE           = DEF_PRICE,
    parameter int MAX_CREDIT      = DEF_MAX_CREDIT,
    parameter int CREDIT_W        = 8,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_n,
    input  logic                coin_d,
    input  logic                coin_q,
    input  logic                select,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                eject_q,
    output logic                eject_d,
    output logic                eject_n,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy
);

    localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                dispense_nx, coin_reject_nx, deny_nx, busy_nx;

    logic                coin_any, coin_multi;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;

    logic                chg_start, chg_q, chg_d, chg_n, chg_done;
    logic [CREDIT_W-1:0] chg_credit;

    assign coin_any   = coin_q | coin_d | coin_n;
    assign coin_multi = (coin_q & coin_d) | (coin_q & coin_n) | (coin_d & coin_n);

    always_comb begin
        coin_val = '0;
        if (coin_q)      coin_val = CREDIT_W'(VAL_Q);
        else if (coin_d) coin_val = CREDIT_W'(VAL_D);
        else if (coin_n) coin_val = CREDIT_W'(VAL_N);
    end

    // One extra bit so the ceiling check cannot wrap.
    assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

    assign chg_start = (state == CHANGE);

    change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
        .start       (chg_start),
        .credit      (credit),
        .eject_q     (chg_q),
        .eject_d     (chg_d),
        .eject_n     (chg_n),
        .credit_next (chg_credit),
        .done        (chg_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            credit      <= '0;
            cnt         <= '0;
            dispense    <= 1'b0;
            eject_q     <= 1'b0;
            eject_d     <= 1'b0;
            eject_n     <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            cnt         <= cnt_nx;
            dispense    <= dispense_nx;
            eject_q     <= chg_q;
            eject_d     <= chg_d;
            eject_n     <= chg_n;
            coin_reject <= coin_reject_nx;
            deny        <= deny_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        credit_nx      = credit;
        cnt_nx         = cnt;
        dispense_nx    = 1'b0;
        coin_reject_nx = 1'b0;
        deny_nx        = 1'b0;

        case (state)
            IDLE, COLLECT: begin
                // cancel beats select beats coin; a coin that loses to a
                // request is refused rather than silently kept.
                if (cancel) begin
                    coin_reject_nx = coin_any;
                    if (credit != '0) state_nx = CHANGE;
                end else if (select) begin
                    coin_reject_nx = coin_any;
                    if (credit >= PRICE_C) begin
                        credit_nx   = credit - PRICE_C;
                        state_nx    = DISPENSE;
                        dispense_nx = 1'b1;
                        cnt_nx      = CNT_LOAD;
                    end else begin
                        deny_nx = 1'b1;
                    end
                end else if (coin_any) begin
                    if (coin_sum > MAX_C) begin
                        coin_reject_nx = 1'b1;
                    end else begin
                        credit_nx      = coin_sum[CREDIT_W-1:0];
                        state_nx       = COLLECT;
                        coin_reject_nx = coin_multi;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_nx = coin_any;
                if (cnt == '0) begin
                    state_nx = (credit != '0) ? CHANGE : IDLE;
                end else begin
                    cnt_nx      = cnt - 1'b1;
                    dispense_nx = 1'b1;
                end
            end
            CHANGE: begin
                coin_reject_nx = coin_any;
                credit_nx      = chg_credit;
                if (chg_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == DISPENSE) || (state_nx == CHANGE);
    end

endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;

    localparam int EJ_Q = 1;
    localparam int EJ_D = 2;
    localparam int EJ_N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0;
    logic       select = 1'b0, cancel = 1'b0;
    logic [7:0] credit;
    logic       dispense, eject_q, eject_d, eject_n, coin_reject, deny, busy;

    int tests = 0;
    int fails = 0;
    int ej_seen = 0;
    int exp_q[$];

    vend_controller dut (
        .clk         (clk),
        .reset       (reset),
        .coin_n      (coin_n),
        .coin_d      (coin_d),
        .coin_q      (coin_q),
        .select      (select),
        .cancel      (cancel),
        .credit      (credit),
        .dispense    (dispense),
        .eject_q     (eject_q),
        .eject_d     (eject_d),
        .eject_n     (eject_n),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Eject monitor: every eject pulse is popped from the scoreboard.
    always @(negedge clk) begin
        if (reset && (eject_q || eject_d || eject_n)) begin
            int got;
            int want;
            ej_seen++;
            got = eject_q ? EJ_Q : (eject_d ? EJ_D : EJ_N);
            tests++;
            if (int'(eject_q) + int'(eject_d) + int'(eject_n) > 1) begin
                fails++;
                $display("FAIL one_hot_eject: got q=%0b d=%0b n=%0b, need at most one", eject_q, eject_d, eject_n);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_eject: got coin code %0d, need no eject", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL eject_order: got coin code %0d, need %0d", got, want);
                end
            end
        end
    end

    task automatic apply(input logic q, input logic d, input logic n, input logic s, input logic c);
        coin_q = q; coin_d = d; coin_n = n; select = s; cancel = c;
        @(posedge clk); #1;
        coin_q = 0; coin_d = 0; coin_n = 0; select = 0; cancel = 0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic count_dispense(output int n);
        n = 0;
        while (dispense === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: got %0d ejects pending busy=%0b, need 0 pending busy=0", name, exp_q.size(), busy);
            exp_q.delete();
        end
        tests++;
        if (credit !== 8'd0) begin
            fails++;
            $display("FAIL %s_final_credit: got %0d, need 0", name, credit);
        end
    endtask

    task automatic test_reset();
        int seen;
        #2 reset = 1'b0;
        idle(2);
        tests++;
        if ({credit, dispense, eject_q, eject_d, eject_n, coin_reject, deny, busy} !== 15'd0) begin
            fails++;
            $display("FAIL reset_state: got credit=%0d outs=%b, need all 0", credit,
                     {dispense, eject_q, eject_d, eject_n, coin_reject, deny, busy});
        end
        reset = 1'b1;
        idle(1);
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        tests++;
        if (credit !== 8'd40) begin
            fails++;
            $display("FAIL reset_build_credit: got %0d, need 40", credit);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({credit, dispense, eject_q, eject_d, eject_n, coin_reject, deny, busy} !== 15'd0) begin
            fails++;
            $display("FAIL reset_midtxn: got credit=%0d outs=%b, need all 0", credit,
                     {dispense, eject_q, eject_d, eject_n, coin_reject, deny, busy});
        end
        idle(2);
        reset = 1'b1;
        seen = ej_seen;
        idle(6);
        tests++;
        if (ej_seen != seen || credit !== 8'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_change: got %0d ejects credit=%0d busy=%0b, need 0 ejects credit=0 busy=0",
                     ej_seen - seen, credit, busy);
        end
    endtask

    task automatic test_exact_price();
        int n;
        for (int i = 1; i <= 3; i++) begin
            apply(1, 0, 0, 0, 0);
            tests++;
            if (credit !== 8'(25 * i)) begin
                fails++;
                $display("FAIL exact_credit_%0d: got %0d, need %0d", i, credit, 25 * i);
            end
        end
        apply(0, 0, 0, 1, 0);
        tests++;
        if (credit !== 8'd0 || dispense !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL exact_select: got credit=%0d dispense=%0b busy=%0b, need 0 1 1", credit, dispense, busy);
        end
        count_dispense(n);
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL exact_dispense_len: got %0d cycles, need 4", n);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL exact_back_idle: got busy=%0b, need 0", busy);
        end
        wait_drain("exact");
    endtask

    task automatic test_change_after_dispense();
        int n;
        repeat (4) apply(1, 0, 0, 0, 0);
        exp_q.push_back(EJ_Q);
        apply(0, 0, 0, 1, 0);
        tests++;
        if (credit !== 8'd25 || dispense !== 1'b1) begin
            fails++;
            $display("FAIL change_select: got credit=%0d dispense=%0b, need 25 1", credit, dispense);
        end
        count_dispense(n);
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL change_dispense_len: got %0d cycles, need 4", n);
        end
        wait_drain("change");
    endtask

    task automatic test_deny_cancel();
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        apply(0, 0, 0, 1, 0);
        tests++;
        if (deny !== 1'b1 || credit !== 8'd15 || dispense !== 1'b0) begin
            fails++;
            $display("FAIL deny_pulse: got deny=%0b credit=%0d dispense=%0b, need 1 15 0", deny, credit, dispense);
        end
        idle(1);
        tests++;
        if (deny !== 1'b0) begin
            fails++;
            $display("FAIL deny_single: got deny=%0b, need 0", deny);
        end
        exp_q.push_back(EJ_D);
        exp_q.push_back(EJ_N);
        apply(0, 0, 0, 0, 1);
        wait_drain("refund");
    endtask

    task automatic test_limits();
        repeat (7) apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        tests++;
        if (credit !== 8'd190) begin
            fails++;
            $display("FAIL limit_build: got %0d, need 190", credit);
        end
        apply(1, 0, 0, 0, 0);
        tests++;
        if (coin_reject !== 1'b1 || credit !== 8'd190) begin
            fails++;
            $display("FAIL limit_reject: got reject=%0b credit=%0d, need 1 190", coin_reject, credit);
        end
        apply(0, 1, 0, 0, 0);
        tests++;
        if (coin_reject !== 1'b0 || credit !== 8'd200) begin
            fails++;
            $display("FAIL limit_fill: got reject=%0b credit=%0d, need 0 200", coin_reject, credit);
        end
        repeat (8) exp_q.push_back(EJ_Q);
        apply(0, 0, 0, 0, 1);
        wait_drain("limit");
        apply(1, 1, 0, 0, 0);
        tests++;
        if (coin_reject !== 1'b1 || credit !== 8'd25) begin
            fails++;
            $display("FAIL multi_coin: got reject=%0b credit=%0d, need 1 25", coin_reject, credit);
        end
        exp_q.push_back(EJ_Q);
        apply(0, 0, 0, 0, 1);
        wait_drain("multi");
    endtask

    task automatic test_cancel_wins();
        int k = 0;
        repeat (3) apply(1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        exp_q.push_back(EJ_Q);
        exp_q.push_back(EJ_Q);
        exp_q.push_back(EJ_Q);
        exp_q.push_back(EJ_N);
        apply(0, 0, 0, 1, 1);
        tests++;
        if (dispense !== 1'b0 || deny !== 1'b0 || busy !== 1'b1 || credit !== 8'd80) begin
            fails++;
            $display("FAIL cancel_wins: got dispense=%0b deny=%0b busy=%0b credit=%0d, need 0 0 1 80",
                     dispense, deny, busy, credit);
        end
        apply(0, 1, 0, 0, 0);
        tests++;
        if (coin_reject !== 1'b1 || credit !== 8'd55) begin
            fails++;
            $display("FAIL change_coin_reject: got reject=%0b credit=%0d, need 1 55", coin_reject, credit);
        end
        while (busy === 1'b1 && k < 20) begin
            tests++;
            if (dispense !== 1'b0) begin
                fails++;
                $display("FAIL cancel_no_dispense: got dispense=%0b, need 0", dispense);
            end
            @(posedge clk); #1;
            k++;
        end
        wait_drain("cancel");
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change_after_dispense();
        test_deny_cancel();
        test_limits();
        test_cancel_wins();
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Vending-machine transaction controller. It consumes the single-cycle pulses produced by the per-button debounce/edge-detect stage: coin-insert, select and cancel. It tracks inserted credit, dispenses one product when credit covers PRICE, and returns change or refunds as a sequence of single-cycle coin-eject pulses. It sits between the debounce stages and the display/actuator drivers.

Parameters:
PRICE, 75, product price in cents; must be a multiple of 5 and no greater than MAX_CREDIT.
MAX_CREDIT, 200, maximum credit in cents; a coin that would exceed it is rejected.
CREDIT_W, 8, width of the credit register; must satisfy 2^CREDIT_W > MAX_CREDIT.
DISPENSE_CYCLES, 4, number of cycles the dispense output is held high.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
coin_n  input  1  nickel inserted, 5c, one-cycle pulse
coin_d  input  1  dime inserted, 10c, one-cycle pulse
coin_q  input  1  quarter inserted, 25c, one-cycle pulse
select  input  1  purchase request, one-cycle pulse
cancel  input  1  refund request, one-cycle pulse
credit  output  CREDIT_W  current credit in cents
dispense  output  1  product actuator; high for DISPENSE_CYCLES cycles
eject_q  output  1  return one quarter (one-cycle pulse)
eject_d  output  1  return one dime (one-cycle pulse)
eject_n  output  1  return one nickel (one-cycle pulse)
coin_reject  output  1  coin refused (one-cycle pulse)
deny  output  1  select with insufficient credit (one-cycle pulse)
busy  output  1  high in DISPENSE and CHANGE states

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-low. While reset is low:
  - state=IDLE; credit=0;
  - dispense, eject_*, coin_reject, deny, busy all 0;
  - the dispense counter is 0.
- Reset mid-transaction aborts the transaction. Any credit is discarded and no change is returned.
- All outputs are registered. Each response appears on the cycle after the input pulse.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Coin acceptance (IDLE/COLLECT only):
  - Value = 25 if coin_q, else 10 if coin_d, else 5 if coin_n (priority q > d > n).
  - If more than one coin pulse arrives in a cycle, the winner is processed and coin_reject pulses once for the losers.
  - If credit+value > MAX_CREDIT, the coin is rejected: coin_reject=1 and credit is unchanged.
  - Otherwise credit += value. IDLE moves to COLLECT on the first accepted coin.
- Coins arriving in DISPENSE or CHANGE are rejected: coin_reject=1 and credit is unchanged.
- select in IDLE/COLLECT:
  - If credit >= PRICE: credit -= PRICE, go to DISPENSE, dispense=1, counter loaded with DISPENSE_CYCLES-1.
  - Otherwise: deny=1 and the state is unchanged.
- cancel in IDLE/COLLECT:
  - If credit > 0, go to CHANGE.
  - If credit == 0, cancel is ignored.
- Priority in the same cycle: cancel > select > coin.
  - A coin arriving alongside select or cancel is rejected.
  - select arriving with cancel is ignored (no deny).
- select and cancel are ignored in DISPENSE and CHANGE.
- DISPENSE:
  - dispense stays high for exactly DISPENSE_CYCLES cycles.
  - On the last cycle: go to CHANGE if credit > 0, else go to IDLE.
- CHANGE (greedy return, one coin per cycle):
  - If credit >= 25: eject_q and credit -= 25.
  - Else if credit >= 10: eject_d and credit -= 10.
  - Else: eject_n and credit -= 5.
  - When the decrement brings credit to 0, the next state is IDLE.
  - At most one eject_* output is high in any cycle.
- busy = (state == DISPENSE || state == CHANGE).
- COLLECT returns to IDLE only through DISPENSE/CHANGE. Credit never goes negative or exceeds MAX_CREDIT.
- Credit arithmetic is unsigned CREDIT_W-bit. The over-limit check uses a CREDIT_W+1-bit sum so it cannot wrap.

Decomposition:
- Shared package vend_pkg:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE);
  - coin-value constants VAL_N=5, VAL_D=10, VAL_Q=25;
  - default PRICE and MAX_CREDIT.
- One natural sub-module, change_dispenser: the greedy CHANGE-state decrementer. It takes start and credit in and produces eject_q/d/n plus done.
- The main FSM, coin arbitration and dispense counter stay in vend_controller.

Test Plan:
- Reset low mid-transaction, with credit=40 in COLLECT → credit=0, IDLE, all outputs 0 immediately; no ejects after reset is released.
- coin_q ×3 then select → credit 25, 50, 75, then 0; dispense high exactly 4 cycles; return to IDLE with no ejects.
- coin_q ×4 (100) then select → dispense 4 cycles, then CHANGE: eject_q once, credit 0, IDLE.
- coin_d + coin_n (15) then select → deny pulse, credit stays 15; cancel → eject_d, then eject_n, credit 0, IDLE.
- Credit 190 then coin_q → coin_reject, credit stays 190; coin_d → credit 200. Simultaneous coin_q+coin_d at credit 0 → credit 25 and coin_reject=1.
- Credit 80 with select and cancel in the same cycle → CHANGE (cancel wins); ejects q, q, q, n; no dispense; coin inserted during CHANGE → coin_reject.
